// File: rtl/parking_gate_ctrl_if.sv
// Lane-side signal bundle for parking_gate_ctrl.
// master : lane/sensor side (drives requests, pass sensors, space flags;
//          observes pulses, barrier drives and status).
// slave  : the gate controller.
interface parking_gate_ctrl_if #(
    parameter int CNT_W = 8
);
    logic             entry_req;
    logic             entry_is_uni;
    logic             entry_pass;
    logic             exit_req;
    logic             exit_is_uni;
    logic             exit_pass;
    logic             uni_is_vacated_space;
    logic             is_vacated_space;

    logic             car_entered;
    logic             is_uni_car_entered;
    logic             car_exited;
    logic             is_uni_car_exited;
    logic             entry_barrier_open;
    logic             exit_barrier_open;
    logic             entry_busy;
    logic             exit_busy;
    logic             entry_denied;
    logic             entry_timeout;
    logic [CNT_W-1:0] denied_count;

    modport master (
        output entry_req, entry_is_uni, entry_pass,
        output exit_req, exit_is_uni, exit_pass,
        output uni_is_vacated_space, is_vacated_space,
        input  car_entered, is_uni_car_entered, car_exited, is_uni_car_exited,
        input  entry_barrier_open, exit_barrier_open, entry_busy, exit_busy,
        input  entry_denied, entry_timeout, denied_count
    );

    modport slave (
        input  entry_req, entry_is_uni, entry_pass,
        input  exit_req, exit_is_uni, exit_pass,
        input  uni_is_vacated_space, is_vacated_space,
        output car_entered, is_uni_car_entered, car_exited, is_uni_car_exited,
        output entry_barrier_open, exit_barrier_open, entry_busy, exit_busy,
        output entry_denied, entry_timeout, denied_count
    );
endinterface

// File: rtl/parking_gate_ctrl.sv
// Entry/exit barrier controller feeding parking_logic.
// Each lane runs its own FSM; every output is a register (Moore).
//
// Ports:
//   clk   - system clock, rising edge
//   reset - asynchronous, active-high
//   bus   - parking_gate_ctrl_if.slave: lane requests, pass sensors and
//           space flags in; count pulses, car-type flags, barrier drives,
//           busy/deny/timeout status and saturating denied_count out.
//
// Entry FSM
//   state | meaning
//   IDLE  | waiting for entry_req, space checked against the car's class
//   OPEN  | barrier up, waiting for entry_pass or timeout
//   DENY  | one-cycle refusal (entry_denied pulse)
//   CLOSE | barrier held down CLOSE_CYCLES cycles
// Exit FSM
//   state | meaning
//   IDLE  | waiting for exit_req
//   OPEN  | barrier up, waiting for exit_pass or timeout
//   CLOSE | barrier held down CLOSE_CYCLES cycles
//
// CLOSE_CYCLES must be >= 2 so parking_logic's space flags have settled
// after a count before the next request is evaluated.
module parking_gate_ctrl #(
    parameter int TIMEOUT_CYCLES = 16,
    parameter int CLOSE_CYCLES   = 4,
    parameter int CNT_W          = 8
) (
    input logic              clk,
    input logic              reset,
    parking_gate_ctrl_if.slave bus
);

    localparam logic [CNT_W-1:0] OPEN_LAST  = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0] CLOSE_LAST = CNT_W'(CLOSE_CYCLES - 1);

    typedef enum logic [1:0] {E_IDLE, E_OPEN, E_DENY, E_CLOSE} entry_state_t;
    typedef enum logic [1:0] {X_IDLE, X_OPEN, X_CLOSE} exit_state_t;

    entry_state_t     entry_state;
    logic [CNT_W-1:0] entry_timer;
    logic             entry_uni;
    logic             car_entered;
    logic             is_uni_car_entered;
    logic             entry_barrier_open;
    logic             entry_busy;
    logic             entry_denied;
    logic             entry_timeout;
    logic [CNT_W-1:0] denied_count;

    exit_state_t      exit_state;
    logic [CNT_W-1:0] exit_timer;
    logic             exit_uni;
    logic             car_exited;
    logic             is_uni_car_exited;
    logic             exit_barrier_open;
    logic             exit_busy;

    logic             space_ok;

    // Space flag matching the class of the car currently requesting.
    assign space_ok = bus.entry_is_uni ? bus.uni_is_vacated_space : bus.is_vacated_space;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            entry_state        <= E_IDLE;
            entry_timer        <= '0;
            entry_uni          <= 1'b0;
            car_entered        <= 1'b0;
            is_uni_car_entered <= 1'b0;
            entry_barrier_open <= 1'b0;
            entry_busy         <= 1'b0;
            entry_denied       <= 1'b0;
            entry_timeout      <= 1'b0;
            denied_count       <= '0;
        end else begin
            car_entered        <= 1'b0;
            is_uni_car_entered <= 1'b0;
            entry_denied       <= 1'b0;
            entry_timeout      <= 1'b0;
            case (entry_state)
                E_IDLE: begin
                    if (bus.entry_req) begin
                        entry_uni   <= bus.entry_is_uni;
                        entry_timer <= '0;
                        entry_busy  <= 1'b1;
                        if (space_ok) begin
                            entry_state        <= E_OPEN;
                            entry_barrier_open <= 1'b1;
                        end else begin
                            entry_state  <= E_DENY;
                            entry_denied <= 1'b1;
                            if (~&denied_count)
                                denied_count <= denied_count + 1'b1;
                        end
                    end
                end
                E_OPEN: begin
                    // Pass is checked first so it wins over a simultaneous timeout.
                    if (bus.entry_pass) begin
                        entry_state        <= E_CLOSE;
                        entry_barrier_open <= 1'b0;
                        entry_timer        <= '0;
                        car_entered        <= 1'b1;
                        is_uni_car_entered <= entry_uni;
                    end else if (entry_timer == OPEN_LAST) begin
                        entry_state        <= E_CLOSE;
                        entry_barrier_open <= 1'b0;
                        entry_timer        <= '0;
                        entry_timeout      <= 1'b1;
                    end else begin
                        entry_timer <= entry_timer + 1'b1;
                    end
                end
                E_DENY: begin
                    entry_state <= E_CLOSE;
                    entry_timer <= '0;
                end
                E_CLOSE: begin
                    if (entry_timer == CLOSE_LAST) begin
                        entry_state <= E_IDLE;
                        entry_busy  <= 1'b0;
                    end else begin
                        entry_timer <= entry_timer + 1'b1;
                    end
                end
                default: begin
                    entry_state        <= E_IDLE;
                    entry_barrier_open <= 1'b0;
                    entry_busy         <= 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            exit_state        <= X_IDLE;
            exit_timer        <= '0;
            exit_uni          <= 1'b0;
            car_exited        <= 1'b0;
            is_uni_car_exited <= 1'b0;
            exit_barrier_open <= 1'b0;
            exit_busy         <= 1'b0;
        end else begin
            car_exited        <= 1'b0;
            is_uni_car_exited <= 1'b0;
            case (exit_state)
                X_IDLE: begin
                    if (bus.exit_req) begin
                        exit_uni          <= bus.exit_is_uni;
                        exit_timer        <= '0;
                        exit_busy         <= 1'b1;
                        exit_state        <= X_OPEN;
                        exit_barrier_open <= 1'b1;
                    end
                end
                X_OPEN: begin
                    if (bus.exit_pass) begin
                        exit_state        <= X_CLOSE;
                        exit_barrier_open <= 1'b0;
                        exit_timer        <= '0;
                        car_exited        <= 1'b1;
                        is_uni_car_exited <= exit_uni;
                    end else if (exit_timer == OPEN_LAST) begin
                        // Exit timeout is silent: the car is simply not counted.
                        exit_state        <= X_CLOSE;
                        exit_barrier_open <= 1'b0;
                        exit_timer        <= '0;
                    end else begin
                        exit_timer <= exit_timer + 1'b1;
                    end
                end
                X_CLOSE: begin
                    if (exit_timer == CLOSE_LAST) begin
                        exit_state <= X_IDLE;
                        exit_busy  <= 1'b0;
                    end else begin
                        exit_timer <= exit_timer + 1'b1;
                    end
                end
                default: begin
                    exit_state        <= X_IDLE;
                    exit_barrier_open <= 1'b0;
                    exit_busy         <= 1'b0;
                end
            endcase
        end
    end

    assign bus.car_entered        = car_entered;
    assign bus.is_uni_car_entered = is_uni_car_entered;
    assign bus.car_exited         = car_exited;
    assign bus.is_uni_car_exited  = is_uni_car_exited;
    assign bus.entry_barrier_open = entry_barrier_open;
    assign bus.exit_barrier_open  = exit_barrier_open;
    assign bus.entry_busy         = entry_busy;
    assign bus.exit_busy          = exit_busy;
    assign bus.entry_denied       = entry_denied;
    assign bus.entry_timeout      = entry_timeout;
    assign bus.denied_count       = denied_count;

endmodule

// File: tb/tb_parking_gate_ctrl.sv
module tb_parking_gate_ctrl;
    localparam int TO  = 16;
    localparam int CC  = 4;
    localparam int CW  = 8;
    localparam int SAT = (1 << CW) - 1;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int total = 0;
    int bad = 0;
    int model_denied = 0;

    // observations gathered by run_lanes, cycle index c counts from the
    // first cycle after the request was sampled
    int o_open_n, o_first_open, o_last_open, o_ent_n, o_ent_at, o_ent_uni, o_stray;
    int o_to_n, o_to_at, o_den_n, o_busy_n;
    int o_xopen_n, o_xfirst_open, o_x_n, o_x_at, o_x_uni, o_xbusy_n;

    parking_gate_ctrl_if #(.CNT_W(CW)) bus ();

    parking_gate_ctrl #(.TIMEOUT_CYCLES(TO), .CLOSE_CYCLES(CC), .CNT_W(CW)) dut (
        .clk(clk), .reset(reset), .bus(bus)
    );

    always #5 clk = ~clk;

    // Present one request per lane for a single cycle, pulse each pass sensor
    // at cycle d / xd (negative = never), and record what the lanes do.
    task automatic run_lanes(input bit en, input bit u, input bit us, input bit s, input int d,
                             input bit ex, input bit xu, input int xd, input int ncyc);
        @(posedge clk); #1;
        bus.entry_req = en; bus.entry_is_uni = u;
        bus.uni_is_vacated_space = us; bus.is_vacated_space = s;
        bus.exit_req = ex; bus.exit_is_uni = xu;
        @(posedge clk); #1;
        bus.entry_req = 1'b0; bus.exit_req = 1'b0;
        bus.entry_is_uni = 1'($urandom); bus.exit_is_uni = 1'($urandom);
        o_open_n = 0; o_first_open = -1; o_last_open = -1; o_ent_n = 0; o_ent_at = -1;
        o_ent_uni = -1; o_stray = 0; o_to_n = 0; o_to_at = -1; o_den_n = 0; o_busy_n = 0;
        o_xopen_n = 0; o_xfirst_open = -1; o_x_n = 0; o_x_at = -1; o_x_uni = -1; o_xbusy_n = 0;
        for (int c = 0; c < ncyc; c++) begin
            bus.entry_pass = (c == d);
            bus.exit_pass  = (c == xd);
            @(negedge clk);
            if (bus.entry_barrier_open) begin
                if (o_open_n == 0) o_first_open = c;
                o_last_open = c;
                o_open_n++;
            end
            if (bus.car_entered) begin o_ent_n++; o_ent_at = c; o_ent_uni = int'(bus.is_uni_car_entered); end
            else if (bus.is_uni_car_entered) o_stray++;
            if (bus.entry_timeout) begin o_to_n++; o_to_at = c; end
            if (bus.entry_denied) o_den_n++;
            if (bus.entry_busy) o_busy_n++;
            if (bus.exit_barrier_open) begin
                if (o_xopen_n == 0) o_xfirst_open = c;
                o_xopen_n++;
            end
            if (bus.car_exited) begin o_x_n++; o_x_at = c; o_x_uni = int'(bus.is_uni_car_exited); end
            else if (bus.is_uni_car_exited) o_stray++;
            if (bus.exit_busy) o_xbusy_n++;
            @(posedge clk); #1;
        end
        bus.entry_pass = 1'b0;
        bus.exit_pass  = 1'b0;
    endtask

    task automatic test_reset();
        bus.entry_req = 0; bus.entry_is_uni = 0; bus.entry_pass = 0;
        bus.exit_req = 0; bus.exit_is_uni = 0; bus.exit_pass = 0;
        bus.uni_is_vacated_space = 0; bus.is_vacated_space = 0;
        reset = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        total++;
        if ({bus.car_entered, bus.is_uni_car_entered, bus.car_exited, bus.is_uni_car_exited,
             bus.entry_barrier_open, bus.exit_barrier_open, bus.entry_busy, bus.exit_busy,
             bus.entry_denied, bus.entry_timeout} !== 10'b0) begin
            bad++; $display("FAIL reset_flags got=%b exp=0", {bus.car_entered, bus.entry_barrier_open,
                            bus.exit_barrier_open, bus.entry_busy, bus.exit_busy});
        end
        total++;
        if (bus.denied_count !== 8'd0) begin
            bad++; $display("FAIL reset_denied_count got=%0d exp=0", bus.denied_count);
        end
        @(posedge clk); #1;
        reset = 1'b0;
        model_denied = 0;
        @(negedge clk);
        total++;
        if ({bus.entry_busy, bus.exit_busy, bus.entry_barrier_open} !== 3'b0) begin
            bad++; $display("FAIL after_reset_idle got=%b exp=000",
                            {bus.entry_busy, bus.exit_busy, bus.entry_barrier_open});
        end
    endtask

    task automatic test_entry_basic();
        run_lanes(1, 0, 0, 1, 2, 0, 0, -1, 12);
        total++; if (o_first_open !== 0) begin bad++; $display("FAIL basic_open_latency got=%0d exp=0", o_first_open); end
        total++; if (o_open_n !== 3) begin bad++; $display("FAIL basic_open_cycles got=%0d exp=3", o_open_n); end
        total++; if (o_ent_n !== 1) begin bad++; $display("FAIL basic_entered_count got=%0d exp=1", o_ent_n); end
        total++; if (o_ent_at !== 3) begin bad++; $display("FAIL basic_entered_at got=%0d exp=3", o_ent_at); end
        total++; if (o_ent_uni !== 0) begin bad++; $display("FAIL basic_entered_type got=%0d exp=0", o_ent_uni); end
        total++; if (o_busy_n !== 3 + CC) begin bad++; $display("FAIL basic_busy got=%0d exp=%0d", o_busy_n, 3 + CC); end
        total++; if (o_to_n !== 0) begin bad++; $display("FAIL basic_timeout got=%0d exp=0", o_to_n); end
    endtask

    task automatic test_deny_saturation();
        int opens;
        run_lanes(1, 1, 0, 1, -1, 0, 0, -1, 6);
        model_denied = 1;
        total++; if (o_den_n !== 1) begin bad++; $display("FAIL deny_pulse got=%0d exp=1", o_den_n); end
        total++; if (o_open_n !== 0) begin bad++; $display("FAIL deny_opened got=%0d exp=0", o_open_n); end
        total++; if (bus.denied_count !== 8'(model_denied)) begin
            bad++; $display("FAIL deny_count_first got=%0d exp=%0d", bus.denied_count, model_denied); end
        total++; if (o_busy_n !== 1 + CC) begin bad++; $display("FAIL deny_busy got=%0d exp=%0d", o_busy_n, 1 + CC); end
        opens = 0;
        for (int i = 1; i < 300; i++) begin
            run_lanes(1, 1, 0, 1, -1, 0, 0, -1, 6);
            opens += o_open_n;
            if (model_denied < SAT) model_denied++;
            if (i == 100) begin
                total++; if (bus.denied_count !== 8'(model_denied)) begin
                    bad++; $display("FAIL deny_count_mid got=%0d exp=%0d", bus.denied_count, model_denied); end
            end
        end
        total++; if (bus.denied_count !== 8'(SAT)) begin
            bad++; $display("FAIL deny_count_saturate got=%0d exp=%0d", bus.denied_count, SAT); end
        total++; if (opens !== 0) begin bad++; $display("FAIL deny_never_open got=%0d exp=0", opens); end
    endtask

    task automatic test_timeout();
        run_lanes(1, 1, 1, 0, -1, 0, 0, -1, 24);
        total++; if (o_open_n !== TO) begin bad++; $display("FAIL timeout_open_cycles got=%0d exp=%0d", o_open_n, TO); end
        total++; if (o_to_n !== 1 || o_to_at !== TO) begin
            bad++; $display("FAIL timeout_pulse got=%0d@%0d exp=1@%0d", o_to_n, o_to_at, TO); end
        total++; if (o_ent_n !== 0) begin bad++; $display("FAIL timeout_no_entry got=%0d exp=0", o_ent_n); end
    endtask

    task automatic test_both_lanes();
        run_lanes(1, 1, 1, 0, 4, 1, 0, 4, 12);
        total++; if (o_ent_at !== 5 || o_x_at !== 5) begin
            bad++; $display("FAIL both_same_cycle got=%0d/%0d exp=5/5", o_ent_at, o_x_at); end
        total++; if (o_ent_uni !== 1 || o_x_uni !== 0) begin
            bad++; $display("FAIL both_types got=%0d/%0d exp=1/0", o_ent_uni, o_x_uni); end
        total++; if (o_stray !== 0) begin bad++; $display("FAIL both_stray_type got=%0d exp=0", o_stray); end
    endtask

    task automatic test_random();
        bit u, us, s, ex, xu, allowed;
        int d, xd, e_open, e_busy, x_open, x_busy;
        for (int it = 0; it < 30; it++) begin
            u = 1'($urandom); us = 1'($urandom); s = 1'($urandom);
            ex = ($urandom_range(0, 3) != 0); xu = 1'($urandom);
            d = $urandom_range(0, 24); xd = $urandom_range(0, 24);
            run_lanes(1, u, us, s, d, ex, xu, xd, 30);
            allowed = u ? us : s;
            e_open = allowed ? ((d < TO) ? d + 1 : TO) : 0;
            e_busy = allowed ? e_open + CC : 1 + CC;
            if (!allowed && model_denied < SAT) model_denied++;
            x_open = ex ? ((xd < TO) ? xd + 1 : TO) : 0;
            x_busy = ex ? x_open + CC : 0;
            total++; if (o_open_n !== e_open || (e_open > 0 && o_first_open !== 0)) begin
                bad++; $display("FAIL rnd_entry_open it=%0d got=%0d@%0d exp=%0d@0", it, o_open_n, o_first_open, e_open); end
            total++; if (o_ent_n !== ((allowed && d < TO) ? 1 : 0)) begin
                bad++; $display("FAIL rnd_entered it=%0d got=%0d", it, o_ent_n); end
            if (allowed && d < TO) begin
                total++; if (o_ent_at !== d + 1 || o_ent_uni !== int'(u)) begin
                    bad++; $display("FAIL rnd_entered_when it=%0d got=%0d/%0d exp=%0d/%0d", it, o_ent_at, o_ent_uni, d + 1, u); end
            end
            total++; if (o_to_n !== ((allowed && d >= TO) ? 1 : 0)) begin
                bad++; $display("FAIL rnd_timeout it=%0d got=%0d", it, o_to_n); end
            total++; if (o_den_n !== (allowed ? 0 : 1)) begin
                bad++; $display("FAIL rnd_denied it=%0d got=%0d exp=%0d", it, o_den_n, !allowed); end
            total++; if (o_busy_n !== e_busy) begin
                bad++; $display("FAIL rnd_entry_busy it=%0d got=%0d exp=%0d", it, o_busy_n, e_busy); end
            total++; if (bus.denied_count !== 8'(model_denied)) begin
                bad++; $display("FAIL rnd_denied_count it=%0d got=%0d exp=%0d", it, bus.denied_count, model_denied); end
            total++; if (o_xopen_n !== x_open || o_xbusy_n !== x_busy) begin
                bad++; $display("FAIL rnd_exit_open it=%0d got=%0d/%0d exp=%0d/%0d", it, o_xopen_n, o_xbusy_n, x_open, x_busy); end
            total++; if (o_x_n !== ((ex && xd < TO) ? 1 : 0)) begin
                bad++; $display("FAIL rnd_exited it=%0d got=%0d", it, o_x_n); end
            if (ex && xd < TO) begin
                total++; if (o_x_at !== xd + 1 || o_x_uni !== int'(xu)) begin
                    bad++; $display("FAIL rnd_exited_when it=%0d got=%0d/%0d exp=%0d/%0d", it, o_x_at, o_x_uni, xd + 1, xu); end
            end
            total++; if (o_stray !== 0) begin bad++; $display("FAIL rnd_stray_type it=%0d got=%0d exp=0", it, o_stray); end
        end
    endtask

    task automatic test_pass_ignored_and_held();
        int ent_n, open_at7, open_at8;
        ent_n = 0;
        bus.is_vacated_space = 1'b1; bus.entry_is_uni = 1'b0;
        for (int c = 0; c < 4; c++) begin
            bus.entry_pass = (c % 2 == 0);
            @(negedge clk);
            if (bus.car_entered) ent_n++;
            @(posedge clk); #1;
        end
        bus.entry_pass = 1'b0;
        total++; if (ent_n !== 0) begin bad++; $display("FAIL idle_pass_counted got=%0d exp=0", ent_n); end

        bus.entry_req = 1'b1;
        @(posedge clk); #1;
        ent_n = 0; open_at7 = -1; open_at8 = -1;
        for (int c = 0; c < 10; c++) begin
            bus.entry_pass = (c == 2 || c == 5);
            @(negedge clk);
            if (bus.car_entered) ent_n++;
            if (c == 7) open_at7 = int'(bus.entry_barrier_open);
            if (c == 8) open_at8 = int'(bus.entry_barrier_open);
            @(posedge clk); #1;
        end
        bus.entry_pass = 1'b0;
        bus.entry_req = 1'b0;
        total++; if (ent_n !== 1) begin bad++; $display("FAIL close_pass_counted got=%0d exp=1", ent_n); end
        total++; if (open_at7 !== 0 || open_at8 !== 1) begin
            bad++; $display("FAIL held_regrant got=%0d%0d exp=01", open_at7, open_at8); end
        repeat (30) @(posedge clk);
        #1;
    endtask

    task automatic test_reset_mid_open();
        int x_n;
        @(posedge clk); #1;
        bus.exit_req = 1'b1; bus.exit_is_uni = 1'b1;
        @(posedge clk); #1;
        bus.exit_req = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        total++; if (bus.exit_barrier_open !== 1'b1) begin
            bad++; $display("FAIL mid_open_precond got=%b exp=1", bus.exit_barrier_open); end
        #1;
        reset = 1'b1;
        bus.exit_pass = 1'b1;
        #1;
        total++; if (bus.exit_barrier_open !== 1'b0 || bus.exit_busy !== 1'b0) begin
            bad++; $display("FAIL async_reset_close got=%b%b exp=00", bus.exit_barrier_open, bus.exit_busy); end
        x_n = 0;
        repeat (2) begin @(negedge clk); if (bus.car_exited) x_n++; end
        @(posedge clk); #1;
        reset = 1'b0;
        model_denied = 0;
        repeat (3) begin @(negedge clk); if (bus.car_exited) x_n++; @(posedge clk); #1; end
        bus.exit_pass = 1'b0;
        @(negedge clk);
        total++; if (x_n !== 0) begin bad++; $display("FAIL reset_no_exit_pulse got=%0d exp=0", x_n); end
        total++; if (bus.exit_busy !== 1'b0 || bus.exit_barrier_open !== 1'b0) begin
            bad++; $display("FAIL exit_idle_after_reset got=%b%b exp=00", bus.exit_busy, bus.exit_barrier_open); end
        total++; if (bus.denied_count !== 8'd0) begin
            bad++; $display("FAIL reset_clears_count got=%0d exp=0", bus.denied_count); end
    endtask

    initial begin
        test_reset();
        test_entry_basic();
        test_deny_saturation();
        test_reset();
        test_timeout();
        test_both_lanes();
        test_random();
        test_pass_ignored_and_held();
        test_reset_mid_open();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
